// File: rtl/mult_div_pkg.sv
// Shared encodings for the multicycle multiply/divide unit.
package mult_div_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_DIV   = 2'b01;
  localparam logic [1:0] MD_MULTU = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/mult_div_abs.sv
// Two's-complement magnitude with sign; invert forces a negation so the same
// block also serves as the result sign fixer.
module mult_div_abs #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] x,
  input  logic              is_signed,
  input  logic              invert,
  output logic [DATA_W-1:0] mag,
  output logic              sgn
);

  always_comb begin
    sgn = is_signed & x[DATA_W-1];
    mag = (sgn ^ invert) ? (~x + DATA_W'(1)) : x;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle radix-2 multiply / restoring divide feeding HI/LO.
// Optional MULTDIV_UNSIGNED_EN enables multu/divu via op[1].
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  md_state_e           state;
  logic [CNT_W-1:0]    count;
  logic                op_div;
  logic                neg_main;
  logic                neg_rem;
  logic [DATA_W-1:0]   opnd;
  logic [2*DATA_W-1:0] acc;

  logic                signed_en;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic                sgn_a, sgn_b;
  logic [DATA_W:0]     mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] mul_next, div_next;
  logic [DATA_W-1:0]   fix_hi, fix_lo, hi_fixed;
  logic                unused_fix_hi_sgn, unused_fix_lo_sgn;

`ifdef MULTDIV_UNSIGNED_EN
  assign signed_en = ~op[1];
`else
  logic unused_op_msb;
  assign signed_en     = 1'b1;
  assign unused_op_msb = op[1];
`endif

  mult_div_abs #(.DATA_W(DATA_W)) u_abs_a (
    .x(a), .is_signed(signed_en), .invert(1'b0), .mag(mag_a), .sgn(sgn_a)
  );

  mult_div_abs #(.DATA_W(DATA_W)) u_abs_b (
    .x(b), .is_signed(signed_en), .invert(1'b0), .mag(mag_b), .sgn(sgn_b)
  );

  // Sign correction of the magnitude result: remainder follows the dividend.
  mult_div_abs #(.DATA_W(DATA_W)) u_fix_hi (
    .x(acc[2*DATA_W-1:DATA_W]), .is_signed(1'b0),
    .invert(op_div ? neg_rem : neg_main), .mag(fix_hi), .sgn(unused_fix_hi_sgn)
  );

  mult_div_abs #(.DATA_W(DATA_W)) u_fix_lo (
    .x(acc[DATA_W-1:0]), .is_signed(1'b0),
    .invert(neg_main), .mag(fix_lo), .sgn(unused_fix_lo_sgn)
  );

  // One iteration of each datapath; acc holds {upper, multiplier} or {rem, quot}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[DATA_W-1:1]};
    div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_next  = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                 : {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    // A 2W negation borrows from the upper half unless the lower half is zero.
    hi_fixed  = fix_hi;
    if (!op_div && neg_main && (acc[DATA_W-1:0] != '0)) begin
      hi_fixed = fix_hi - DATA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      op_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            op_div <= op[0];
            if (op[0] && (b == '0)) begin
              state <= S_DONE;
            end else begin
              state    <= S_RUN;
              count    <= CNT_W'(DATA_W);
              neg_main <= sgn_a ^ sgn_b;
              neg_rem  <= sgn_a;
              opnd     <= op[0] ? mag_b : mag_a;
              acc      <= op[0] ? {{DATA_W{1'b0}}, mag_a} : {{DATA_W{1'b0}}, mag_b};
            end
          end
        end
        S_RUN: begin
          acc   <= op_div ? div_next : mul_next;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          hi    <= hi_fixed;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          // Divide-by-zero arrives here without done; it raises done one cycle later.
          if (done) begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            done     <= 1'b1;
            div_zero <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: random and directed ops against an
// arithmetic reference model; a monitor checks every done pulse.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] a, b;
  logic              busy, done, div_zero;
  logic [DATA_W-1:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          next_id = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  mult_div_unit #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp_v);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural meaning of op.
  function automatic void model(input logic [1:0] op_i, input logic [31:0] a_i,
                                input logic [31:0] b_i, output logic [31:0] h,
                                output logic [31:0] l, output logic dz);
    logic   uns;
    logic [63:0] p;
    longint sa, sb, q, r;
`ifdef MULTDIV_UNSIGNED_EN
    uns = op_i[1];
`else
    uns = 1'b0;
`endif
    dz = 1'b0;
    if (!op_i[0]) begin
      if (uns) p = {32'b0, a_i} * {32'b0, b_i};
      else begin
        sa = $signed(a_i);
        sb = $signed(b_i);
        p  = sa * sb;
      end
      h = p[63:32];
      l = p[31:0];
    end else if (b_i == 32'd0) begin
      dz = 1'b1;
      h  = last_hi;
      l  = last_lo;
    end else if (uns) begin
      l = a_i / b_i;
      h = a_i % b_i;
    end else begin
      sa = $signed(a_i);
      sb = $signed(b_i);
      q  = sa / sb;
      r  = sa % sb;
      l  = q[31:0];
      h  = r[31:0];
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("hi#%0d", e.id), hi, e.hi);
        chk($sformatf("lo#%0d", e.id), lo, e.lo);
        chk($sformatf("div_zero#%0d", e.id), 32'(div_zero), 32'(e.dz));
        chk($sformatf("latency#%0d", e.id), 32'(cyc), 32'(e.cyc));
        chk($sformatf("busy_at_done#%0d", e.id), 32'(busy), 32'd1);
      end
    end
  end

  // Issue one request; the caller is positioned at a negedge.
  task automatic issue(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
    exp_t e;
    int   n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      chk("issue_wait_idle", 32'(busy), 32'd0);
      return;
    end
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    @(negedge clk);
    start = 1'b0;
    model(op_i, a_i, b_i, e.hi, e.lo, e.dz);
    if (!e.dz) begin
      last_hi = e.hi;
      last_lo = e.lo;
    end
    e.cyc = cyc + (e.dz ? 1 : DATA_W + 1);
    e.id  = next_id++;
    exp_q.push_back(e);
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    op    = MD_MULT;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_div_zero", 32'(div_zero), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    issue(MD_MULT, 32'd7, 32'hFFFF_FFFD);
    drain();
    chk("mult_7x-3_hi", hi, 32'hFFFF_FFFF);
    chk("mult_7x-3_lo", lo, 32'hFFFF_FFEB);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    drain();
    chk("div_-7/2_lo", lo, 32'hFFFF_FFFD);
    chk("div_-7/2_hi", hi, 32'hFFFF_FFFF);

    // Prime hi/lo with 0x1234/0x5678, then divide by zero.
    issue(MD_DIV, 32'h0ACF_1234, 32'h0000_2000);
    drain();
    issue(MD_DIV, 32'd5, 32'd0);
    drain();
    chk("divzero_hold_hi", hi, 32'h0000_1234);
    chk("divzero_hold_lo", lo, 32'h0000_5678);

    // MIN / -1 with a start pulse mid-run that must be ignored.
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = MD_MULT;
    a     = 32'd3;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_ignored_start", 32'(busy), 32'd1);
    drain();
    chk("div_min_lo", lo, 32'h8000_0000);
    chk("div_min_hi", hi, 32'h0000_0000);

    // Start during the done cycle is ignored.
    issue(MD_MULT, 32'd12345, 32'hFFFF_0000);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    start = 1'b1;
    op    = MD_MULT;
    a     = 32'd5;
    b     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    drain();

`ifdef MULTDIV_UNSIGNED_EN
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    drain();
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    issue(MD_DIVU, 32'hFFFF_FFFF, 32'd10);
    drain();
    chk("divu_lo", lo, 32'h1999_9999);
    chk("divu_hi", hi, 32'h0000_0005);
`endif

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick());
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    repeat (3) @(negedge clk);
    chk("hold_hi", hi, last_hi);
    chk("hold_lo", lo, last_lo);

    // Reset at run cycle 10 aborts: no done, results cleared.
    issue(MD_MULT, 32'h1234_5678, 32'h0000_0FED);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    exp_q.delete();
    last_hi = '0;
    last_lo = '0;
    repeat (DATA_W + 8) @(negedge clk);
    chk("abort_no_done_busy", 32'(busy), 32'd0);

    issue(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    chk("post_abort_lo", lo, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
